// File: rtl/ccff_chain_loader_if.sv
// Bitstream and readback word streams between the programming controller and
// the configuration-chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              cfg_valid;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              rb_valid;
  logic [WORD_W-1:0] rb_data;
  logic              rb_ready;

  modport master (
    output cfg_valid, cfg_data, rb_ready,
    input  cfg_ready, rb_valid, rb_data
  );

  modport slave (
    input  cfg_valid, cfg_data, rb_ready,
    output cfg_ready, rb_valid, rb_data
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words into ccff_head and
// reads the chain back non-destructively by recirculating ccff_tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 80,
  parameter int WORD_W    = 8
) (
  input  logic               prog_clk,
  input  logic               prog_reset,
  input  logic               start_load,
  input  logic               start_read,
  output logic               busy,
  output logic               done,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               shift_en,
  ccff_chain_loader_if.slave bus
);
  localparam int MAX_N = (CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W;
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  total, total_nx;
  // bits left in the word register during LOAD, bits collected during READ
  logic [CNT_W-1:0]  bits, bits_nx;
  logic              shift_en_nx;
  logic              rb_valid, rb_valid_nx;
  logic [WORD_W-1:0] rb_data, rb_data_nx;
  logic [WORD_W-1:0] word_sr, word_sr_nx;
  logic [WORD_W-1:0] col_sr, col_sr_nx;
  logic              cfg_ready;

  // Bits to take from a freshly accepted word: a full word, or the tail remainder.
  function automatic logic [CNT_W-1:0] word_bits(input logic [CNT_W-1:0] left);
    return (left < WORD_CNT) ? left : WORD_CNT;
  endfunction

  // Left-align a partially collected word so its first bit sits in the MSB.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] w,
                                                   input logic [CNT_W-1:0]  n);
    return w << (WORD_CNT - n);
  endfunction

  always_comb begin
    state_nx    = state;
    total_nx    = total;
    bits_nx     = bits;
    word_sr_nx  = word_sr;
    col_sr_nx   = col_sr;
    rb_valid_nx = rb_valid;
    rb_data_nx  = rb_data;
    cfg_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start_load) begin
          state_nx = LOAD;
          total_nx = CHAIN_CNT;
          bits_nx  = '0;
        end else if (start_read) begin
          state_nx = READ;
          total_nx = CHAIN_CNT;
          bits_nx  = '0;
        end
      end
      LOAD: begin
        if (shift_en) begin
          word_sr_nx = word_sr << 1;
          bits_nx    = bits - ONE;
          total_nx   = total - ONE;
        end
        // accept against the post-shift view so word boundaries stay gapless
        cfg_ready = (bits_nx == '0) && (total_nx != '0);
        if (bus.cfg_valid && cfg_ready) begin
          word_sr_nx = bus.cfg_data;
          bits_nx    = word_bits(total_nx);
        end
        if (total_nx == '0) state_nx = DONE;
      end
      READ: begin
        if (shift_en) begin
          col_sr_nx = (col_sr << 1) | WORD_W'(ccff_tail);
          bits_nx   = bits + ONE;
          total_nx  = total - ONE;
          if ((bits_nx == WORD_CNT) || (total_nx == '0)) begin
            rb_valid_nx = 1'b1;
            rb_data_nx  = align_word(col_sr_nx, bits_nx);
            bits_nx     = '0;
          end
        end
        if (rb_valid && bus.rb_ready) begin
          rb_valid_nx = 1'b0;
          if (total == '0) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // shifting pauses while a readback word waits to be taken
    shift_en_nx = ((state_nx == LOAD) && (bits_nx != '0)) ||
                  ((state_nx == READ) && (total_nx != '0) && !rb_valid_nx);
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state    <= IDLE;
      total    <= '0;
      bits     <= '0;
      shift_en <= 1'b0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      state    <= state_nx;
      total    <= total_nx;
      bits     <= bits_nx;
      shift_en <= shift_en_nx;
      rb_valid <= rb_valid_nx;
      rb_data  <= rb_data_nx;
    end
  end

  always_ff @(posedge prog_clk) begin
    word_sr <= word_sr_nx;
    col_sr  <= col_sr_nx;
  end

  always_comb begin
    case (state)
      LOAD:    ccff_head = shift_en & word_sr[WORD_W-1];
      READ:    ccff_head = ccff_tail;
      default: ccff_head = 1'b0;
    endcase
  end

  assign busy          = (state == LOAD) || (state == READ);
  assign done          = (state == DONE);
  assign bus.cfg_ready = cfg_ready;
  assign bus.rb_valid  = rb_valid;
  assign bus.rb_data   = rb_data;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a behavioural chain on the serial
// side plus queues of expected head bits and readback words.
module tb_ccff_chain_loader;
  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic prog_clk, prog_reset, start_load, start_read;
  logic busy, done, ccff_head, ccff_tail, shift_en;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) bus ();

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .start_load(start_load),
    .start_read(start_read),
    .busy      (busy),
    .done      (done),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .shift_en  (shift_en),
    .bus       (bus)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // the configuration chain itself: head enters at bit 0, tail is the top bit
  logic [CHAIN_LEN-1:0] chain;
  always @(posedge prog_clk) if (shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  assign ccff_tail = chain[CHAIN_LEN-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge prog_clk) cyc++;

  logic              exp_bits[$];
  logic [WORD_W-1:0] exp_words[$];
  logic [WORD_W-1:0] cur_words[NW];
  logic [CHAIN_LEN-1:0] model_bits;   // model_bits[i] = i-th bit of the stream
  int   mode = 0;                     // 0: loading, 1: reading back
  int   shift_cnt, first_shift, last_shift, done_cnt, stall_cycles;
  int   hold_cnt = 0;
  bit   rb_rand = 0;
  bit   stall_prev = 0;
  logic [WORD_W-1:0] held_rb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CHAIN_LEN-1:0] exp_chain();
    logic [CHAIN_LEN-1:0] e;
    for (int i = 0; i < CHAIN_LEN; i++) e[CHAIN_LEN-1-i] = model_bits[i];
    return e;
  endfunction

  // readback consumer: optional initial hold on the first word, optional random stalls
  always @(posedge prog_clk) begin
    #1;
    if (hold_cnt > 0 && bus.rb_valid) begin
      bus.rb_ready = 1'b0;
      hold_cnt--;
    end else if (rb_rand) bus.rb_ready = 1'($urandom_range(0, 1));
    else bus.rb_ready = 1'b1;
  end

  // monitor: pops expectations whenever the DUT presents something
  always @(negedge prog_clk) begin
    if (!prog_reset) begin
      if (shift_en) begin
        shift_cnt++;
        if (first_shift < 0) first_shift = cyc;
        last_shift = cyc;
        chk("shift_while_busy", 64'(busy), 64'(1));
        if (mode == 0) begin
          if (exp_bits.size() == 0) begin
            checks++; errors++;
            $display("FAIL head_extra: got shift of bit %0d expected no shift", ccff_head);
          end else chk("head_bit", 64'(ccff_head), 64'(exp_bits.pop_front()));
        end else chk("recirc", 64'(ccff_head), 64'(ccff_tail));
      end
      if (done) done_cnt++;
      if (bus.rb_valid && bus.rb_ready) begin
        if (exp_words.size() == 0) begin
          checks++; errors++;
          $display("FAIL rb_extra: got word 0x%0h expected none", bus.rb_data);
        end else chk("rb_word", 64'(bus.rb_data), 64'(exp_words.pop_front()));
      end
      if (bus.rb_valid && !bus.rb_ready) begin
        stall_cycles++;
        chk("stall_shift", 64'(shift_en), 64'(0));
        if (stall_prev) chk("rb_hold", 64'(bus.rb_data), 64'(held_rb));
        stall_prev = 1'b1;
        held_rb    = bus.rb_data;
      end else stall_prev = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge prog_clk);
    while (!bus.cfg_ready && n < 200) begin
      @(negedge prog_clk);
      n++;
    end
    if (!bus.cfg_ready) begin
      checks++; errors++;
      $display("FAIL cfg_ready_timeout: got ready 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = w;
    wait_ready();
    @(posedge prog_clk); #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    @(negedge prog_clk);
    while (!done && n < limit) begin
      @(negedge prog_clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
    @(negedge prog_clk);
    chk("done_pulse_once", 64'(done_cnt), 64'(1));
    chk("busy_after_done", 64'(busy), 64'(0));
  endtask

  task automatic build_load_model();
    for (int i = 0; i < CHAIN_LEN; i++) begin
      model_bits[i] = cur_words[i / WORD_W][WORD_W-1-(i % WORD_W)];
      exp_bits.push_back(model_bits[i]);
    end
  endtask

  task automatic do_load(input int gap, input bit both, input bit poke);
    mode = 0; shift_cnt = 0; first_shift = -1; done_cnt = 0;
    exp_bits.delete();
    build_load_model();
    @(posedge prog_clk); #1;
    start_load = 1'b1;
    start_read = both;
    @(posedge prog_clk); #1;
    start_load = 1'b0;
    start_read = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (k > 0 && gap > 0) begin
        wait_ready();
        repeat (gap) @(posedge prog_clk);
        #1;
      end
      send_word(cur_words[k]);
      if (k == 0 && poke) begin
        start_read = 1'b1;
        @(posedge prog_clk); #1;
        start_read = 1'b0;
      end
    end
    wait_done(400);
    chk("load_bits_left", 64'(exp_bits.size()), 64'(0));
    chk("load_shift_count", 64'(shift_cnt), 64'(CHAIN_LEN));
    chk("load_shift_span", 64'(last_shift - first_shift + 1), 64'(CHAIN_LEN + gap * (NW - 1)));
    chk("chain_after_load", 64'(chain), 64'(exp_chain()));
  endtask

  task automatic do_read(input int hold, input bit rnd);
    logic [WORD_W-1:0] w;
    mode = 1; shift_cnt = 0; first_shift = -1; done_cnt = 0; stall_cycles = 0;
    exp_words.delete();
    for (int k = 0; k < NW; k++) begin
      w = '0;
      for (int b = 0; b < WORD_W; b++)
        if (k * WORD_W + b < CHAIN_LEN) w[WORD_W-1-b] = model_bits[k * WORD_W + b];
      exp_words.push_back(w);
    end
    hold_cnt = hold;
    rb_rand  = rnd;
    @(posedge prog_clk); #1;
    start_read = 1'b1;
    @(posedge prog_clk); #1;
    start_read = 1'b0;
    wait_done(600);
    rb_rand = 1'b0;
    chk("read_words_left", 64'(exp_words.size()), 64'(0));
    chk("read_shift_count", 64'(shift_cnt), 64'(CHAIN_LEN));
    chk("chain_after_read", 64'(chain), 64'(exp_chain()));
    if (hold > 0) chk("stall_len_ok", 64'(stall_cycles >= hold), 64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1);
  end

  initial begin
    prog_reset = 1'b1;
    start_load = 1'b0;
    start_read = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("rst_busy",      64'(busy),          64'(0));
    chk("rst_done",      64'(done),          64'(0));
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'(0));
    chk("rst_rb_valid",  64'(bus.rb_valid),  64'(0));
    chk("rst_rb_data",   64'(bus.rb_data),   64'(0));
    chk("rst_head",      64'(ccff_head),     64'(0));
    chk("rst_shift_en",  64'(shift_en),      64'(0));
    prog_reset = 1'b0;

    // directed stream 1010_0101_0011_1100_1111
    cur_words[0] = 8'hA5; cur_words[1] = 8'h3C; cur_words[2] = 8'hF0;
    do_load(0, 0, 0);
    chk("chain_pattern", 64'(chain), 64'(20'b1010_0101_0011_1100_1111));
    do_load(3, 0, 0);
    chk("chain_pattern_gap", 64'(chain), 64'(20'b1010_0101_0011_1100_1111));
    do_read(0, 0);
    do_read(0, 0);
    do_read(5, 0);

    // simultaneous starts choose load; a start_read during load is ignored
    cur_words[0] = 8'h5A; cur_words[1] = 8'hC3; cur_words[2] = 8'h0F;
    do_load(0, 1, 1);
    do_read(0, 0);

    // reset after ten shifts of a load
    mode = 0; shift_cnt = 0; first_shift = -1; done_cnt = 0;
    exp_bits.delete();
    cur_words[0] = 8'h96; cur_words[1] = 8'h69; cur_words[2] = 8'hE1;
    build_load_model();
    @(posedge prog_clk); #1;
    start_load = 1'b1;
    @(posedge prog_clk); #1;
    start_load = 1'b0;
    send_word(cur_words[0]);
    send_word(cur_words[1]);
    repeat (2) @(posedge prog_clk);
    #2;
    chk("pre_rst_shifts", 64'(shift_cnt), 64'(10));
    prog_reset = 1'b1;
    #1;
    chk("arst_busy",      64'(busy),          64'(0));
    chk("arst_done",      64'(done),          64'(0));
    chk("arst_cfg_ready", 64'(bus.cfg_ready), 64'(0));
    chk("arst_rb_valid",  64'(bus.rb_valid),  64'(0));
    chk("arst_rb_data",   64'(bus.rb_data),   64'(0));
    chk("arst_head",      64'(ccff_head),     64'(0));
    chk("arst_shift_en",  64'(shift_en),      64'(0));
    @(posedge prog_clk); #1;
    prog_reset = 1'b0;
    exp_bits.delete();
    do_load(0, 0, 0);
    do_read(0, 0);

    // randomized words, gaps and readback backpressure
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < NW; k++) cur_words[k] = WORD_W'($urandom);
      do_load(int'($urandom_range(0, 3)), 0, 0);
      do_read(int'($urandom_range(0, 2)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
